alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port valid_i, input, 1 bit: request valid.
REQ-005 The block SHALL have port ready_o, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port funct_i, input, 6 bits: R-type function code.
REQ-007 The block SHALL have port ALUOp_i, input, 2 bits: op class (2'b10 R-type, 2'b00 add).
REQ-008 The block SHALL have ports data1_i and data2_i, input, WIDTH bits each: operands.
REQ-009 The block SHALL have port valid_o, output, 1 bit: result valid.
REQ-010 The block SHALL have port ready_i, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port data_o, output, WIDTH bits: the result.
REQ-012 The block SHALL have port zero_o, output, 1 bit: data_o equals 0, qualified by valid_o.
REQ-013 The block SHALL have port err_o, output, 1 bit: illegal op, qualified by valid_o.

Function
REQ-014 The block SHALL accept a request only on a cycle where valid_i=1 and ready_o=1, and SHALL capture funct_i, ALUOp_i, data1_i and data2_i on that cycle.
REQ-015 The block SHALL decode ALUOp 00 as add, and ALUOp 10 with funct 100100/100101/100000/100010/011000 as and/or/add/sub/mul respectively; every other combination SHALL be illegal.
REQ-016 The block SHALL have three states, IDLE, MUL and DONE; ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE.
REQ-017 From IDLE, on accept, the block SHALL go to MUL for a mul and to DONE for any other op; the and/or/add/sub/illegal result SHALL be registered so that valid_o rises exactly 1 cycle after accept.
REQ-018 A mul SHALL be computed iteratively by shift-and-add, one multiplier bit per cycle, taking exactly WIDTH cycles in MUL; valid_o SHALL rise exactly WIDTH+1 cycles after accept.
REQ-019 All arithmetic SHALL wrap modulo 2^WIDTH, with operands unsigned; mul SHALL return the low WIDTH bits of the product, and sub SHALL return data1 - data2.
REQ-020 An illegal op SHALL produce data_o=0, zero_o=1 and err_o=1; all legal ops SHALL produce err_o=0.
REQ-021 In DONE, data_o, zero_o and err_o SHALL hold stable until ready_i=1; the transition DONE->IDLE SHALL occur on the cycle where valid_o=1 and ready_i=1.
REQ-022 ready_i while not in DONE SHALL be ignored, and valid_i while ready_o=0 SHALL be ignored; no request SHALL be queued.
REQ-023 Minimum issue interval SHALL be 3 cycles for single-cycle ops: accept, DONE with ready_i=1, then IDLE.

Reset
REQ-024 While rst_i=1 the block SHALL force state IDLE, ready_o=1, valid_o=0, data_o=0, zero_o=0, err_o=0, and SHALL clear the iteration counter and accumulator.
REQ-025 Assertion of rst_i in MUL or DONE SHALL abort the operation immediately, asynchronously; the result SHALL be discarded and no valid_o pulse SHALL follow.
REQ-026 After rst_i deasserts, a request SHALL be acceptable on the first rising edge.

Configuration
REQ-027 When macro ALU_SEQ_SLT_EN is defined, funct 101010 with ALUOp 10 SHALL be legal slt, data_o = {WIDTH-1 zeros, (signed data1 < signed data2)}, with latency 1.
REQ-028 When ALU_SEQ_SLT_EN is undefined, funct 101010 SHALL be illegal per REQ-020.

Verification (WIDTH=32)
REQ-029 The bench SHALL apply add 0xFFFFFFFF+0x00000001 with ALUOp 10 funct 100000 and SHALL require valid_o 1 cycle later with data_o=0, zero_o=1, err_o=0.
REQ-030 The bench SHALL apply mul 0x00010003*0x00020005 and SHALL require valid_o at accept+33 cycles with data_o=0x000B000F and ready_o=0 throughout.
REQ-031 The bench SHALL apply sub 5-7 with ready_i held 0 for 10 cycles and SHALL require data_o=0xFFFFFFFE held stable and valid_o=1, returning to IDLE the cycle after ready_i=1.
REQ-032 The bench SHALL apply ALUOp 01 and SHALL require data_o=0, err_o=1; it SHALL also apply funct 101010 with -1,1 and require data_o=1 when ALU_SEQ_SLT_EN is defined, else err_o=1.
REQ-033 The bench SHALL pulse rst_i at mul iteration 10 and SHALL require an immediate return to IDLE, no valid_o, and that a subsequent and 0xF0F0F0F0&0xFF00FF00 gives 0xF000F000.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle and/or/add/sub, WIDTH-cycle shift-and-add multiply,
// valid/ready on both sides. Define ALU_SEQ_SLT_EN to add signed set-less-than.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [5:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             zero_reg, zero_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             op_mul;
  logic             op_illegal;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_sum;

  // Decode of the request as presented; only consumed on an accept cycle.
  always_comb begin
    op_mul     = 1'b0;
    op_illegal = 1'b0;
    alu_result = '0;
    if (ALUOp_i == 2'b00) begin
      alu_result = data1_i + data2_i;
    end else if (ALUOp_i == 2'b10) begin
      case (funct_i)
        6'b100100: alu_result = data1_i & data2_i;
        6'b100101: alu_result = data1_i | data2_i;
        6'b100000: alu_result = data1_i + data2_i;
        6'b100010: alu_result = data1_i - data2_i;
        6'b011000: op_mul = 1'b1;
`ifdef ALU_SEQ_SLT_EN
        6'b101010: alu_result = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
`endif
        default:   op_illegal = 1'b1;
      endcase
    end else begin
      op_illegal = 1'b1;
    end
  end

  // Partial product for the current multiplier bit: the multiplicand or zero.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_sum = acc_reg + addend;

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    zero_next   = zero_reg;
    err_next    = err_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          if (op_mul) begin
            acc_next    = '0;
            mcand_next  = data1_i;
            mplier_next = data2_i;
            cnt_next    = '0;
            state_next  = MUL;
          end else begin
            data_next  = alu_result;
            zero_next  = (alu_result == '0);
            err_next   = op_illegal;
            state_next = DONE;
          end
        end
      end
      MUL: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          data_next  = acc_sum;
          zero_next  = (acc_sum == '0);
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      data_reg   <= '0;
      zero_reg   <= 1'b0;
      err_reg    <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      zero_reg   <= zero_next;
      err_reg    <= err_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign ready_o = (state_reg == IDLE);
  assign valid_o = (state_reg == DONE);
  assign data_o  = data_reg;
  assign zero_o  = zero_reg;
  assign err_o   = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): a latency/result model checked every cycle, plus
// directed vectors with literal expectations. Honours ALU_SEQ_SLT_EN if defined.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [5:0]   funct_i;
  logic [1:0]   ALUOp_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .funct_i(funct_i), .ALUOp_i(ALUOp_i), .data1_i(data1_i), .data2_i(data2_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .zero_o(zero_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the op definitions.
  function automatic logic is_legal(input logic [5:0] f, input logic [1:0] op);
    if (op == 2'b00) return 1'b1;
    if (op != 2'b10) return 1'b0;
    case (f)
      6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000: return 1'b1;
`ifdef ALU_SEQ_SLT_EN
      6'b101010: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_res(input logic [5:0] f, input logic [1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    if (!is_legal(f, op)) return '0;
    if (op == 2'b00) return a + b;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (f)
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b011000: return prod[W-1:0];
      default:   return ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [5:0] f, input logic [1:0] op);
    return (op == 2'b10 && f == 6'b011000) ? W + 1 : 1;
  endfunction

  // Model: cycles still to wait for a result, and whether a result is on offer.
  int           m_wait;
  logic         m_have;
  logic [W-1:0] m_res;
  logic         m_err;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_wait <= 0;
      m_have <= 1'b0;
      m_res  <= '0;
      m_err  <= 1'b0;
    end else if (m_have) begin
      if (ready_i) m_have <= 1'b0;
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_have <= 1'b1;
    end else if (valid_i) begin
      m_res <= exp_res(funct_i, ALUOp_i, data1_i, data2_i);
      m_err <= !is_legal(funct_i, ALUOp_i);
      if (exp_lat(funct_i, ALUOp_i) == 1) m_have <= 1'b1;
      else m_wait <= exp_lat(funct_i, ALUOp_i) - 1;
    end
  end

  always @(negedge clk_i) begin
    check("cmp_ready", {63'd0, ready_o}, {63'd0, (!m_have && m_wait == 0)});
    check("cmp_valid", {63'd0, valid_o}, {63'd0, m_have});
    if (m_have) begin
      check("cmp_data", {32'd0, data_o}, {32'd0, m_res});
      check("cmp_zero", {63'd0, zero_o}, {63'd0, (m_res == '0)});
      check("cmp_err",  {63'd0, err_o},  {63'd0, m_err});
    end
  end

  // Starts at a negedge, ends at a negedge with the block back in IDLE.
  task automatic run(input string name, input logic [5:0] f, input logic [1:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b, input int lat_exp,
                     input logic [W-1:0] d_exp, input logic z_exp, input logic e_exp,
                     input int hold);
    int lat;
    valid_i = 1'b1; funct_i = f; ALUOp_i = op; data1_i = a; data2_i = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    check({name, "_lat"},  lat, lat_exp);
    check({name, "_data"}, {32'd0, data_o}, {32'd0, d_exp});
    check({name, "_zero"}, {63'd0, zero_o}, {63'd0, z_exp});
    check({name, "_err"},  {63'd0, err_o},  {63'd0, e_exp});
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1; funct_i = 6'b100100; ALUOp_i = 2'b10; data1_i = '1; data2_i = '1;
      @(negedge clk_i);
      check({name, "_hold_data"},  {32'd0, data_o}, {32'd0, d_exp});
      check({name, "_hold_valid"}, {63'd0, valid_o}, 64'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check({name, "_idle_ready"}, {63'd0, ready_o}, 64'd1);
    check({name, "_idle_valid"}, {63'd0, valid_o}, 64'd0);
    txn++;
    $display("TXN %0d %s a=%h b=%h data=%h zero=%0b err=%0b lat=%0d",
             txn, name, a, b, d_exp, z_exp, e_exp, lat);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    funct_i = '0; ALUOp_i = '0; data1_i = '0; data2_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_data",  {32'd0, data_o}, 64'd0);
    check("rst_zero",  {63'd0, zero_o}, 64'd0);
    check("rst_err",   {63'd0, err_o},  64'd0);
    rst_i = 1'b0;

    run("add_wrap", 6'b100000, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0, 1'b1, 1'b0, 0);
    run("mul",      6'b011000, 2'b10, 32'h0001_0003, 32'h0002_0005, 33, 32'h000B_000F, 1'b0, 1'b0, 0);
    run("sub_hold", 6'b100010, 2'b10, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0, 1'b0, 10);
    run("aluop01",  6'b100000, 2'b01, 32'h12, 32'h34, 1, 32'h0, 1'b1, 1'b1, 0);
`ifdef ALU_SEQ_SLT_EN
    run("slt",      6'b101010, 2'b10, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1'b0, 1'b0, 0);
`else
    run("slt_ill",  6'b101010, 2'b10, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 1'b1, 0);
`endif
    run("bad_fn",   6'b000000, 2'b10, 32'h5, 32'h6, 1, 32'h0, 1'b1, 1'b1, 0);
    run("aluop11",  6'b100000, 2'b11, 32'h5, 32'h6, 1, 32'h0, 1'b1, 1'b1, 0);
    run("add00",    6'b111111, 2'b00, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0, 1'b0, 0);
    run("mul_ones", 6'b011000, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, 1'b0, 1'b0, 0);
    run("mul_zero", 6'b011000, 2'b10, 32'h0, 32'h1234_5678, 33, 32'h0, 1'b1, 1'b0, 0);
    run("or",       6'b100101, 2'b10, 32'h0F0F_0000, 32'h0000_00F0, 1, 32'h0F0F_00F0, 1'b0, 1'b0, 0);

    // Abort a multiply partway through with an asynchronous reset pulse.
    valid_i = 1'b1; funct_i = 6'b011000; ALUOp_i = 2'b10; data1_i = 32'h3; data2_i = 32'h5;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("mul_busy_ready", {63'd0, ready_o}, 64'd0);
    #2 rst_i = 1'b1;
    #1;
    check("abort_ready", {63'd0, ready_o}, 64'd1);
    check("abort_valid", {63'd0, valid_o}, 64'd0);
    check("abort_data",  {32'd0, data_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("and_after_rst", 6'b100100, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 1'b0, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("no_stray_valid", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
